// File: rtl/cpu_pkg.sv
// Shared core definitions: architectural widths, the end-of-trace marker
// and the fetch queue entry layout.
package cpu_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 32;

  // An all-zero instruction word marks the end of the program trace.
  localparam logic [INSTR_W-1:0] END_OF_TRACE = 32'h0;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instr, pc} entries between the
// instruction memory response and decode. Flush empties it in one cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Guard against writing a full queue or reading an empty one.
  always_comb begin
    do_push = push && (count != CW'(DEPTH));
    do_pop  = pop  && (count != '0);
  end

  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read per cycle to
// instruction memory, tags each response with its PC and buffers it in the
// fetch queue for decode. Stops at the end-of-trace word; redirect flushes
// everything and restarts at a new PC.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     fq_valid,
  output logic [INSTR_W-1:0]       fq_instr,
  output logic [ADDR_W-1:0]        fq_pc,
  input  logic                     fq_ready,
  output logic [$clog2(DEPTH):0]   fq_count,
  output logic                     halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              resp_live;
  logic              fq_push;
  logic              fq_pop;
  logic              hit_eot;
  logic [EW-1:0]     head_data;

  // Handshake to decode: the head entry transfers in a cycle where fq_valid
  // and fq_ready are both high; fq_valid never depends on fq_ready, and a
  // redirect in the same cycle cancels the transfer.
  assign fq_valid = (fq_count != '0);
  assign fq_pop   = fq_valid && fq_ready && !redirect_valid;

  // Issue only when the queue can hold every outstanding word. No credit is
  // taken for a same-cycle pop, so a full queue always blocks issue.
  always_comb begin
    occupancy = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
    issue     = rst_n && !halted && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    resp_live = inflight && !halted && !redirect_valid;
    hit_eot   = resp_live && (imem_rdata == END_OF_TRACE);
    fq_push   = resp_live && (imem_rdata != END_OF_TRACE);
  end

  assign imem_req  = issue;
  assign imem_addr = pc;

  // PC, in-flight tag and halt tracking; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= {redirect_pc[ADDR_W-1:2], 2'b00};
      inflight    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(4);
      end
      if (hit_eot) begin
        halted <= 1'b1;
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fq_push),
    .push_data ({imem_rdata, inflight_pc}),
    .pop       (fq_pop),
    .flush     (redirect_valid),
    .head_data (head_data),
    .count     (fq_count)
  );

  assign fq_instr = head_data[EW-1:ADDR_W];
  assign fq_pc    = head_data[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder, a stream model of what decode must
// see (consecutive words from the last restart PC up to the first zero word),
// a per-cycle compare process, and directed scenarios with literal checks.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int          AW     = 12;
  localparam int          DEPTH  = 4;
  localparam int          CW     = $clog2(DEPTH) + 1;
  localparam logic [11:0] RST_PC = 12'hFFC;
  localparam int          W      = $bits(fetch_entry_t);

  logic          tb_clk;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          fq_valid;
  logic [31:0]   fq_instr;
  logic [AW-1:0] fq_pc;
  logic          fq_ready;
  logic [CW-1:0] fq_count;
  logic          halted;

  logic [31:0]   mem [1024];
  logic [W-1:0]  exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  fetch_unit #(
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (tb_clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fq_valid       (fq_valid),
    .fq_instr       (fq_instr),
    .fq_pc          (fq_pc),
    .fq_ready       (fq_ready),
    .fq_count       (fq_count),
    .halted         (halted)
  );

  // ---------------- clock ----------------
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  function automatic logic [31:0] orig_word(input logic [9:0] idx);
    return (idx == 10'h200) ? 32'h0 : (32'h1000_0000 + {22'b0, idx});
  endfunction

  // Expected decode stream after a restart at start: consecutive words,
  // wrapping at the top of the address space, ending before the first zero.
  task automatic rebuild(input logic [11:0] start);
    logic [11:0] a;
    logic [31:0] w;
    fetch_entry_t e;
    exp_q.delete();
    a = {start[11:2], 2'b00};
    for (int k = 0; k < 1024; k++) begin
      w = mem[a[11:2]];
      if (w == 32'h0) break;
      e.instr = w;
      e.pc    = a;
      exp_q.push_back(W'(e));
      a = a + 12'd4;
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    logic        pend;
    logic [11:0] pend_addr;
    pend       = 1'b0;
    pend_addr  = '0;
    imem_rdata = '0;
    forever begin
      @(negedge tb_clk);
      if (pend) imem_rdata = mem[pend_addr[11:2]];
      else      imem_rdata = $urandom() | 32'h1;
      pend      = imem_req;
      pend_addr = imem_addr;
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] want;
    forever begin
      @(negedge tb_clk);
      if (!rst_n) begin
        rebuild(RST_PC);
      end else if (redirect_valid) begin
        rebuild(redirect_pc);
      end else begin
        check("valid_vs_count", fq_valid, fq_count != '0);
        check("count_le_depth", fq_count <= CW'(DEPTH), 1);
        if (fq_count == CW'(DEPTH)) check("no_req_when_full", imem_req, 0);
        if (halted) check("no_req_when_halted", imem_req, 0);
        if (imem_req) check("addr_aligned", imem_addr[1:0], 0);
        if (fq_valid && fq_ready) begin
          got = {fq_instr, fq_pc};
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL deliver_extra: got pc %0h instr %0h expected nothing", fq_pc, fq_instr);
          end else begin
            want = exp_q.pop_front();
            check("deliver", got, want);
          end
        end
      end
    end
  end

  // ---------------- directed + random scenarios ----------------
  initial begin
    int          nv;
    logic [11:0] rp;
    logic [11:0] zpos;
    logic        zset;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fq_ready       = 1'b0;
    zpos           = '0;
    zset           = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = orig_word(10'(i));

    // Reset values
    tick(2);
    @(negedge tb_clk);
    check("rst_fq_valid", fq_valid, 0);
    check("rst_fq_count", fq_count, 0);
    check("rst_halted", halted, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_fq_instr", fq_instr, 0);
    check("rst_fq_pc", fq_pc, 0);

    // Startup latency and wrap from RESET_PC = FFC
    tick(1);
    rst_n    = 1'b1;
    fq_ready = 1'b1;
    @(negedge tb_clk);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 12'hFFC);
    check("c0_valid", fq_valid, 0);
    @(negedge tb_clk);
    check("c1_valid", fq_valid, 0);
    @(negedge tb_clk);
    check("c2_valid", fq_valid, 1);
    check("c2_pc", fq_pc, 12'hFFC);
    check("c2_instr", fq_instr, 32'h1000_03FF);
    @(negedge tb_clk);
    check("c3_pc", fq_pc, 12'h000);
    check("c3_instr", fq_instr, 32'h1000_0000);
    @(negedge tb_clk);
    check("c4_pc", fq_pc, 12'h004);

    // Throughput: one instruction per cycle
    nv = 0;
    repeat (20) begin
      @(negedge tb_clk);
      if (fq_valid) nv++;
    end
    check("throughput", nv, 20);

    // Backpressure
    tick(1);
    fq_ready = 1'b0;
    tick(10);
    @(negedge tb_clk);
    check("bp_count", fq_count, 4);
    check("bp_req", imem_req, 0);
    check("bp_valid", fq_valid, 1);
    tick(1);
    fq_ready = 1'b1;
    tick(10);

    // Redirect with 3 entries queued and one response in flight
    redirect_valid = 1'b1;
    redirect_pc    = 12'h040;
    fq_ready       = 1'b0;
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    fq_ready       = 1'b1;
    @(negedge tb_clk);
    check("pre_redir_count", fq_count, 3);
    check("redir_req", imem_req, 0);
    tick(1);
    redirect_valid = 1'b0;
    @(negedge tb_clk);
    check("post_redir_count", fq_count, 0);
    check("post_redir_valid", fq_valid, 0);
    @(negedge tb_clk);
    check("redir_c2_valid", fq_valid, 0);
    @(negedge tb_clk);
    check("redir_c3_valid", fq_valid, 1);
    check("redir_c3_pc", fq_pc, 12'h100);
    check("redir_c3_instr", fq_instr, 32'h1000_0040);
    tick(10);

    // End of trace at 0x010
    mem[4]         = 32'h0;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h000;
    tick(1);
    redirect_valid = 1'b0;
    tick(25);
    @(negedge tb_clk);
    check("eot_halted", halted, 1);
    check("eot_req", imem_req, 0);
    check("eot_count", fq_count, 0);
    check("eot_all_delivered", exp_q.size(), 0);
    tick(1);
    mem[4]         = orig_word(10'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h000;
    tick(1);
    redirect_valid = 1'b0;
    @(negedge tb_clk);
    check("restart_halted", halted, 0);
    check("restart_req", imem_req, 1);
    check("restart_addr", imem_addr, 12'h000);
    tick(1);

    // Randomised redirects, terminators and backpressure
    repeat (40) begin
      rp = 12'($urandom_range(0, 4095));
      if (zset) mem[zpos[11:2]] = orig_word(zpos[11:2]);
      zset = 1'($urandom_range(0, 1));
      if (zset) begin
        zpos = {rp[11:2], 2'b00} + 12'(4 * $urandom_range(0, 10));
        mem[zpos[11:2]] = 32'h0;
      end
      redirect_valid = 1'b1;
      redirect_pc    = rp;
      fq_ready       = ($urandom_range(0, 1) != 0);
      tick(1);
      redirect_valid = 1'b0;
      repeat ($urandom_range(5, 40)) begin
        fq_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
    end
    if (zset) mem[zpos[11:2]] = orig_word(zpos[11:2]);

    // Asynchronous reset mid-stream
    redirect_valid = 1'b1;
    redirect_pc    = 12'h000;
    fq_ready       = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    check("pre_reset_valid", fq_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", fq_valid, 0);
    check("async_count", fq_count, 0);
    check("async_halted", halted, 0);
    check("async_req", imem_req, 0);
    @(posedge tb_clk);
    #1;
    rst_n = 1'b1;
    @(negedge tb_clk);
    check("rerun_req", imem_req, 1);
    check("rerun_addr", imem_addr, RST_PC);
    tick(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
